// File: rtl/cordic_arb_if.sv
// Bus bundle for cordic_arb: requester handshake, CORDIC engine drive/return and response stream.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface cordic_arb_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_deg;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       cor_deg;
  logic [WIDTH-1:0]       cor_sin;
  logic [WIDTH-1:0]       cor_cos;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_sin;
  logic [WIDTH-1:0]       rsp_cos;
  logic                   busy;

  modport slave (
    input  req_valid, req_deg, cor_sin, cor_cos, rsp_ready,
    output req_ready, cor_deg, rsp_valid, rsp_id, rsp_sin, rsp_cos, busy
  );

  modport master (
    output req_valid, req_deg, cor_sin, cor_cos, rsp_ready,
    input  req_ready, cor_deg, rsp_valid, rsp_id, rsp_sin, rsp_cos, busy
  );
endinterface

// File: rtl/cordic_arb.sv
// Shares one fixed-latency CORDIC engine between N_REQ requesters with credit-based response buffering.
// Define CORDIC_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module cordic_arb #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 16,
  parameter int CORDIC_LAT = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  cordic_arb_if.slave  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] sin;
    logic [WIDTH-1:0] cos;
  } rsp_t;

  logic [CORDIC_LAT-1:0] tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]       tag_id_q [CORDIC_LAT];
  logic [ID_W-1:0]       tag_id_d [CORDIC_LAT];
  rsp_t                  fifo_q   [FIFO_DEPTH];
  rsp_t                  fifo_d   [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W:0]        outstanding;
  logic                  credit_ok;
  logic                  found;
  logic                  grant;
  logic                  push;
  logic                  pop;
  logic [ID_W-1:0]       grant_idx;

`ifdef CORDIC_ARB_FIXED_PRIO_EN
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[k]) begin
        found     = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[rr_index(rr_ptr_q, k)]) begin
        found     = 1'b1;
        grant_idx = rr_index(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Credits come from registered counts only, so a pop frees its slot one cycle later.
  assign outstanding = {1'b0, inflight_q} + {1'b0, fifo_count_q};
  assign credit_ok   = outstanding < CREDITS;
  assign grant       = found && credit_ok && rst_n;
  assign push        = tag_valid_q[CORDIC_LAT-1];
  assign pop         = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    bus.req_ready = '0;
    bus.cor_deg   = '0;
    if (grant) begin
      bus.req_ready[grant_idx] = 1'b1;
      bus.cor_deg              = bus.req_deg[grant_idx*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    tag_valid_d = {tag_valid_q[CORDIC_LAT-2:0], grant};
    tag_id_d[0] = grant_idx;
    for (int k = 1; k < CORDIC_LAT; k++) tag_id_d[k] = tag_id_q[k-1];
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q].id  = tag_id_q[CORDIC_LAT-1];
      fifo_d[wr_ptr_q].sin = bus.cor_sin;
      fifo_d[wr_ptr_q].cos = bus.cor_cos;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_comb begin
    fifo_count_d = fifo_count_q;
    inflight_d   = inflight_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    case ({grant, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Storage is cleared on reset so the don't-care head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q  <= '0;
      for (int k = 0; k < CORDIC_LAT; k++) tag_id_q[k] <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) fifo_q[k] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      inflight_q   <= '0;
    end else begin
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      inflight_q   <= inflight_d;
    end
  end

  assign bus.rsp_valid = (fifo_count_q != '0);
  assign bus.rsp_id    = fifo_q[rd_ptr_q].id;
  assign bus.rsp_sin   = fifo_q[rd_ptr_q].sin;
  assign bus.rsp_cos   = fifo_q[rd_ptr_q].cos;
  assign bus.busy      = (inflight_q != '0) || (fifo_count_q != '0);
endmodule

// File: tb/tb_cordic_arb.sv
// Scoreboard bench for cordic_arb; a stand-in engine returns slightly inexact quadrant results
// that the monitor compares against exact hand values with a +/-8 LSB tolerance.
`timescale 1ns/1ps
module tb_cordic_arb;
  localparam int N_REQ      = 4;
  localparam int WIDTH      = 16;
  localparam int CORDIC_LAT = 17;
  localparam int FIFO_DEPTH = 8;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] sin;
    logic [WIDTH-1:0] cos;
    int               exp_cycle;
  } sb_t;

  logic             clk = 1'b0;
  logic             rst_n;
  int               cycle_cnt = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               rr_ptr = 0;
  sb_t              sb_q[$];
  sb_t              mon_e;
  logic [WIDTH-1:0] lane_deg [N_REQ];
  logic [WIDTH-1:0] eng_sin_q [CORDIC_LAT];
  logic [WIDTH-1:0] eng_cos_q [CORDIC_LAT];

  cordic_arb_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  cordic_arb #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .CORDIC_LAT(CORDIC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Stand-in engine outputs, a few LSBs off the exact value like a real CORDIC.
  function automatic logic [WIDTH-1:0] eng_sin(input logic [WIDTH-1:0] a);
    case (a)
      16'h0000: return 16'h0002;
      16'h4000: return 16'h7FFC;
      16'h8000: return 16'hFFFD;
      16'hC000: return 16'h8002;
      default:  return 16'h5555;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] eng_cos(input logic [WIDTH-1:0] a);
    case (a)
      16'h0000: return 16'h7FFD;
      16'h4000: return 16'hFFFE;
      16'h8000: return 16'h8003;
      16'hC000: return 16'h0003;
      default:  return 16'hAAAA;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] ref_sin(input logic [WIDTH-1:0] a);
    case (a)
      16'h4000: return 16'h7FFF;
      16'hC000: return 16'h8001;
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] ref_cos(input logic [WIDTH-1:0] a);
    case (a)
      16'h0000: return 16'h7FFF;
      16'h8000: return 16'h8001;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    eng_sin_q[0] <= eng_sin(bus.cor_deg);
    eng_cos_q[0] <= eng_cos(bus.cor_deg);
    for (int k = 1; k < CORDIC_LAT; k++) begin
      eng_sin_q[k] <= eng_sin_q[k-1];
      eng_cos_q[k] <= eng_cos_q[k-1];
    end
  end
  assign bus.cor_sin = eng_sin_q[CORDIC_LAT-1];
  assign bus.cor_cos = eng_cos_q[CORDIC_LAT-1];

  function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
    int w;
    w = -1;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N_REQ; k++) if (w < 0 && v[k]) w = k;
`else
    for (int k = 0; k < N_REQ; k++) if (w < 0 && v[(ptr + k) % N_REQ]) w = (ptr + k) % N_REQ;
`endif
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkNear(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
    logic [WIDTH-1:0] diff;
    diff = actual - expected;
    n_checks++;
    if ($isunknown(actual) || $signed(diff) > 8 || $signed(diff) < -8) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h +/-8", name, actual, expected);
    end
  endtask

  // One cycle of stimulus; the expected grant is derived from the bench's own arbitration/credit model.
  task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic rdy, output logic [N_REQ-1:0] granted);
    int               exp_id;
    logic [N_REQ-1:0] exp_ready;
    logic [WIDTH-1:0] exp_deg;
    sb_t              e;
    @(negedge clk);
    bus.req_valid = valid;
    bus.rsp_ready = rdy;
    for (int i = 0; i < N_REQ; i++) bus.req_deg[i*WIDTH +: WIDTH] = lane_deg[i];
    #1;
    exp_ready = '0;
    exp_deg   = '0;
    exp_id    = -1;
    if (sb_q.size() < FIFO_DEPTH) exp_id = pick(valid, rr_ptr);
    if (exp_id >= 0) begin
      exp_ready[exp_id] = 1'b1;
      exp_deg           = lane_deg[exp_id];
    end
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("cor_deg", 32'(bus.cor_deg), 32'(exp_deg));
    granted = exp_ready;
    if (exp_id >= 0) begin
      e.id        = exp_id;
      e.sin       = ref_sin(lane_deg[exp_id]);
      e.cos       = ref_cos(lane_deg[exp_id]);
      e.exp_cycle = (sb_q.size() == 0 && rdy) ? cycle_cnt + CORDIC_LAT + 1 : -1;
      sb_q.push_back(e);
      rr_ptr = (exp_id + 1) % N_REQ;
    end
  endtask

  task automatic send(input logic [N_REQ-1:0] mask, input int bound);
    logic [N_REQ-1:0] pending, g;
    int               n;
    pending = mask;
    n       = 0;
    while (pending != '0 && n < bound) begin
      applyStimulus(pending, 1'b1, g);
      pending = pending & ~g;
      n++;
    end
    checkOutput("send_pending", 32'(pending), 32'h0);
  endtask

  task automatic drain(input int bound);
    logic [N_REQ-1:0] g;
    int               n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      applyStimulus('0, 1'b1, g);
      n++;
    end
    checkOutput("drain_left", 32'(sb_q.size()), 32'h0);
    applyStimulus('0, 1'b1, g);
    checkOutput("busy_idle", 32'(bus.busy), 32'h0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_rsp: got rsp id %0d, expected no response", bus.rsp_id);
      end else begin
        mon_e = sb_q[0];
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
        checkNear("rsp_sin", bus.rsp_sin, mon_e.sin);
        checkNear("rsp_cos", bus.rsp_cos, mon_e.cos);
        if (bus.rsp_ready === 1'b1) begin
          if (mon_e.exp_cycle >= 0) checkOutput("rsp_latency", 32'(cycle_cnt), 32'(mon_e.exp_cycle));
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N_REQ-1:0] g;
    int               grants, early, g3;

    bus.req_valid = '0;
    bus.req_deg   = '0;
    bus.rsp_ready = 1'b0;
    lane_deg      = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    rst_n         = 1'b1;
    #1 rst_n      = 1'b0;
    bus.req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("reset_cor_deg", 32'(bus.cor_deg), 32'h0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
    checkOutput("reset_rsp_sin", 32'(bus.rsp_sin), 32'h0);
    checkOutput("reset_rsp_cos", 32'(bus.rsp_cos), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = '0;

    $display("[TB] single request, angle 0");
    send(4'b0001, 5);
    drain(40);

    $display("[TB] quadrant, requester 2 angle 0x4000");
    lane_deg[2] = 16'h4000;
    send(4'b0100, 5);
    drain(40);

    $display("[TB] all requesters valid, round-robin with credit limit");
    lane_deg = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    grants = 0;
    early  = 0;
    for (int cyc = 0; cyc < 60 && grants < 12; cyc++) begin
      applyStimulus('1, 1'b1, g);
      if (bus.req_ready != '0) begin
        grants++;
        if (cyc < 18) early++;
      end
    end
    checkOutput("rr_grants", 32'(grants), 32'd12);
    checkOutput("rr_credit_window", 32'(early), 32'd8);
    drain(80);

    $display("[TB] back-pressure with rsp_ready low");
    grants = 0;
    repeat (30) begin
      applyStimulus('1, 1'b0, g);
      if (bus.req_ready != '0) grants++;
    end
    checkOutput("bp_grants", 32'(grants), 32'd8);
    checkOutput("bp_stalled_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("bp_busy", 32'(bus.busy), 32'h1);
    checkOutput("bp_fifo_full_valid", 32'(bus.rsp_valid), 32'h1);
    applyStimulus('1, 1'b1, g);
    checkOutput("bp_no_grant_on_pop", 32'(bus.req_ready), 32'h0);
    applyStimulus('1, 1'b1, g);
    checkOutput("bp_resume", 32'(bus.req_ready != '0), 32'h1);
    drain(80);

    $display("[TB] reset with requests in flight");
    repeat (5) applyStimulus('1, 1'b1, g);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("midrst_cor_deg", 32'(bus.cor_deg), 32'h0);
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("midrst_rsp_id", 32'(bus.rsp_id), 32'h0);
    checkOutput("midrst_rsp_sin", 32'(bus.rsp_sin), 32'h0);
    checkOutput("midrst_rsp_cos", 32'(bus.rsp_cos), 32'h0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'h0);
    sb_q.delete();
    rr_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = '0;
    repeat (30) applyStimulus('0, 1'b1, g);
    checkOutput("postrst_busy", 32'(bus.busy), 32'h0);
    lane_deg[0] = 16'h0000;
    lane_deg[2] = 16'h8000;
    send(4'b0101, 5);
    drain(40);

    $display("[TB] requesters 1 and 3 held valid");
    lane_deg[1] = 16'h4000;
    lane_deg[3] = 16'hC000;
    g3 = 0;
    repeat (10) begin
      applyStimulus(4'b1010, 1'b1, g);
      if (bus.req_ready[3]) g3++;
    end
`ifdef CORDIC_ARB_FIXED_PRIO_EN
    checkOutput("prio_req3_grants", 32'(g3), 32'd0);
`else
    checkOutput("prio_req3_grants", 32'(g3), 32'd4);
`endif
    send(4'b1000, 30);
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
